// File: rtl/llr_pkg.sv
// Shared definitions for the multi-lane LLR storage.
//   LLR_WIDTH / NUM_LANES : default word width and lanes per address
//   llr_t                 : one LLR word
//   lane_bus_t            : packed lane bus, lane 0 at the LSBs
//   init_state_e          : init engine states (IDLE, CLEAR)
package llr_pkg;

  localparam int LLR_WIDTH = 8;
  localparam int NUM_LANES = 4;

  typedef logic [LLR_WIDTH-1:0]           llr_t;
  typedef logic [NUM_LANES*LLR_WIDTH-1:0] lane_bus_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } init_state_e;

endpackage

// File: rtl/llr_lane_ram.sv
// Single-lane simple dual-port RAM with a registered read port.
//   clk, rst_n        : clock, async active-low reset (read register only)
//   we_i, waddr_i,
//   wdata_i           : write port
//   re_i, raddr_i     : read request; rdata_o loads on the next rising edge
//   rdata_o           : registered read data, holds while re_i is low
// A same-address read and write on one edge returns the pre-write word.
module llr_lane_ram
  import llr_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = LLR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Storage array is deliberately not reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/llr_mbank_ram.sv
// Multi-lane LLR storage: NUM_LANES words share one address and are written
// or read in parallel.
//   clk, rst_n            : clock, async active-low reset
//   init_start            : pulse, starts a clear of the whole memory
//   init_busy             : high while the init engine owns the write port
//   wr_en/wr_addr/wr_data : per-lane masked write
//   rd_en/rd_addr         : read request
//   rd_data/rd_valid      : read result, RD_LATENCY cycles after acceptance
//   dbg_state_o           : current init engine state
// Handshake: a read is accepted on any rising edge where rd_en=1 and
// init_busy=0; there is no backpressure, every accepted read produces exactly
// one rd_valid cycle RD_LATENCY cycles later. rd_data holds between results.
// RD_LATENCY must lie in 1..4.
module llr_mbank_ram #(
  parameter int                     NUM_LANES  = llr_pkg::NUM_LANES,
  parameter int                     ADDR_WIDTH = 8,
  parameter int                     LLR_WIDTH  = llr_pkg::LLR_WIDTH,
  parameter int                     RD_LATENCY = 2,
  parameter int                     RDW_BYPASS = 1,
  parameter logic [LLR_WIDTH-1:0]   INIT_VALUE = '0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           init_start,
  output logic                           init_busy,
  input  logic [NUM_LANES-1:0]           wr_en,
  input  logic [ADDR_WIDTH-1:0]          wr_addr,
  input  logic [NUM_LANES*LLR_WIDTH-1:0] wr_data,
  input  logic                           rd_en,
  input  logic [ADDR_WIDTH-1:0]          rd_addr,
  output logic [NUM_LANES*LLR_WIDTH-1:0] rd_data,
  output logic                           rd_valid,
  output logic                           dbg_state_o
);

  import llr_pkg::*;

  localparam int BUS_W = NUM_LANES * LLR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  // ---------------------------------------------------------------- init FSM
  init_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (init_start) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        cnt_d = cnt_q + ADDR_ONE;
        // Last address cleared this cycle: counter wraps and we hand the
        // write port back.
        if (&cnt_q) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign init_busy   = (state_q == ST_CLEAR);
  assign dbg_state_o = state_q;

  // -------------------------------------------------------------- write mux
  logic [NUM_LANES-1:0]  ram_we;
  logic [ADDR_WIDTH-1:0] ram_waddr;
  logic [BUS_W-1:0]      ram_wdata;
  logic                  rd_accept;

  always_comb begin
    ram_we    = wr_en;
    ram_waddr = wr_addr;
    ram_wdata = wr_data;
    if (init_busy) begin
      ram_we    = '1;
      ram_waddr = cnt_q;
      ram_wdata = {NUM_LANES{INIT_VALUE}};
    end
  end

  assign rd_accept = rd_en & ~init_busy;

  // ------------------------------------------------------------------ lanes
  logic [BUS_W-1:0] ram_rdata;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    llr_lane_ram #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (LLR_WIDTH)
    ) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .we_i    (ram_we[g]),
      .waddr_i (ram_waddr),
      .wdata_i (ram_wdata[g*LLR_WIDTH +: LLR_WIDTH]),
      .re_i    (rd_accept),
      .raddr_i (rd_addr),
      .rdata_o (ram_rdata[g*LLR_WIDTH +: LLR_WIDTH])
    );
  end

  // ------------------------------------------------------- bypass, stage 0
  // The lane RAMs return pre-write data on a same-edge collision. To return
  // new data instead, remember which lanes were written at that edge and what
  // was written, and patch those lanes after the RAM read register.
  logic [NUM_LANES-1:0] byp_mask_q, byp_mask_d;
  logic [BUS_W-1:0]     byp_data_q;
  logic                 v0_q;
  logic [BUS_W-1:0]     s0_data;

  always_comb begin
    byp_mask_d = '0;
    if ((RDW_BYPASS != 0) && (wr_addr == rd_addr)) begin
      byp_mask_d = wr_en;
    end
  end

  // Bypass registers only load on an accepted read so that stage 0 holds
  // its value along with the RAM read registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0_q       <= 1'b0;
      byp_mask_q <= '0;
      byp_data_q <= '0;
    end else begin
      v0_q <= rd_accept;
      if (rd_accept) begin
        byp_mask_q <= byp_mask_d;
        byp_data_q <= wr_data;
      end
    end
  end

  always_comb begin
    s0_data = ram_rdata;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (byp_mask_q[i]) begin
        s0_data[i*LLR_WIDTH +: LLR_WIDTH] = byp_data_q[i*LLR_WIDTH +: LLR_WIDTH];
      end
    end
  end

  // ------------------------------------------------------------ delay line
  // Each stage loads only when the stage before it is valid, so the output
  // holds the last result while rd_valid is low.
  if (RD_LATENCY == 1) begin : g_lat1
    assign rd_data  = s0_data;
    assign rd_valid = v0_q;
  end else begin : g_latn
    logic [RD_LATENCY-2:0] vld_q;
    logic [BUS_W-1:0]      dat_q [RD_LATENCY-1];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= '0;
        for (int j = 0; j < RD_LATENCY-1; j++) begin
          dat_q[j] <= '0;
        end
      end else begin
        vld_q[0] <= v0_q;
        if (v0_q) begin
          dat_q[0] <= s0_data;
        end
        for (int j = 1; j < RD_LATENCY-1; j++) begin
          vld_q[j] <= vld_q[j-1];
          if (vld_q[j-1]) begin
            dat_q[j] <= dat_q[j-1];
          end
        end
      end
    end

    assign rd_data  = dat_q[RD_LATENCY-2];
    assign rd_valid = vld_q[RD_LATENCY-2];
  end

endmodule
